noc_mux: RTL
============

Name: noc_mux

Overview:
- Packet-level N:1 multiplexer merging CHANNELS NoC input links onto one output link.
- Round-robin arbiter grants one input and holds the grant until that packet's last flit is accepted downstream.
- Paired with noc_demux: sits downstream of per-class channels/buffers and feeds a single router port or link.

Parameters:
- FLIT_WIDTH, 32, width of one flit in bits.
- CHANNELS, 2, number of input channels; legal range 1..16.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_flit  input  CHANNELS*FLIT_WIDTH  input flits; channel i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- in_valid  input  CHANNELS  per-channel flit valid.
- in_last  input  CHANNELS  per-channel last-flit-of-packet marker.
- in_ready  output  CHANNELS  per-channel ready; a flit transfers when in_valid[i] & in_ready[i].
- out_flit  output  FLIT_WIDTH  output flit.
- out_valid  output  1  output flit valid.
- out_last  output  1  output last-flit marker.
- out_ready  input  1  downstream ready; a flit transfers when out_valid & out_ready.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant=0, last_grant=CHANNELS-1, so channel 0 has top priority first.
  - Outputs: out_valid=0, out_last=0, out_flit=0, in_ready=0.
- State IDLE:
  - out_valid=0, out_flit=0, out_last=0, in_ready=all 0.
  - If any in_valid: grant <= first channel with in_valid set, searching (last_grant+1) mod CHANNELS upward with wrap; state <= ACTIVE.
  - Otherwise remain in IDLE.
  - Arbitration costs exactly one bubble cycle per packet; the first flit appears on out_* in the cycle after the request is seen.
- State ACTIVE (grant = g):
  - Combinational forward: out_flit=in_flit[g], out_valid=in_valid[g], out_last=in_last[g].
  - in_ready[g]=out_ready; all other in_ready=0.
  - On out_valid & out_ready & out_last: last_grant <= g; state <= IDLE.
  - Otherwise stay in ACTIVE, including while in_valid[g] is low mid-packet (out_valid drops; grant is held; no interleaving).
- Non-granted inputs:
  - Are never acknowledged.
  - Must hold their valid flit; the mux imposes no timeout.
- Grant changes only at packet boundaries (last flit transferred).
- Single-flit packets (in_last set on the head flit): 2 cycles per packet (arbitrate + transfer) when the output is always ready.
- Fairness: with all channels continuously requesting, grants rotate 0,1,...,CHANNELS-1,0,...
- CHANNELS=1: arbiter degenerates; behaviour identical, including the arbitration bubble.
- Async reset asserted mid-packet: grant dropped immediately, partial packet abandoned, outputs return to reset values in the same cycle.
- No flit storage; out_ready must not depend combinationally on out_valid.

Test Plan:
- Reset, then ch0 sends a 3-flit packet (A0,A1,A2) with out_ready=1 -> out_valid low in cycle 0; A0,A1,A2 out in cycles 1-3 with out_last only on A2; in_ready[1]=0 throughout.
- CHANNELS=3, all channels present single-flit packets continuously -> output order ch0,ch1,ch2,ch0,ch1,ch2, each flit separated by one idle cycle.
- ch1 sends a 4-flit packet; ch0 raises valid after flit 1 -> all 4 ch1 flits out contiguously; ch0 is served next with no ch0 flit interleaved.
- Backpressure: out_ready toggles 1,0,0,1,1 during a 3-flit packet -> each flit is held stable while out_ready=0; no flit is duplicated or lost; in_ready[g] mirrors out_ready.
- Granted source stalls: ch2 in_valid low for 2 cycles mid-packet while ch0 requests -> out_valid=0 for those cycles, grant stays on ch2, ch0 in_ready=0.
- Async rst pulse mid-packet on ch0 -> out_valid=0 and in_ready=0 immediately; after release, arbitration restarts with ch0 highest priority.

Source files
------------

// File: rtl/noc_mux.sv
// noc_mux: packet-level N:1 NoC multiplexer with a round-robin arbiter.
// A grant is taken in IDLE (one bubble cycle) and held until the granted
// packet's last flit is accepted downstream; flits are forwarded
// combinationally from the granted channel, so there is no flit storage.
//
// Ports:
//   clk        clock, rising-edge
//   rst        asynchronous active-high reset
//   in_flit    CHANNELS flits, channel i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   in_valid   per-channel flit valid
//   in_last    per-channel last-flit-of-packet marker
//   in_ready   per-channel ready (only the granted channel can see it high)
//   out_flit   output flit
//   out_valid  output flit valid
//   out_last   output last-flit marker
//   out_ready  downstream ready
module noc_mux #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_valid,
  input  logic [CHANNELS-1:0]            in_last,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_valid,
  output logic                           out_last,
  input  logic                           out_ready
);

  localparam int unsigned GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   grant_nxt;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   last_grant_nxt;

  logic [FLIT_WIDTH-1:0] flits [CHANNELS];
  logic [GW-1:0]         pick_wrap;
  logic [GW-1:0]         pick_ahead;
  logic                  found_ahead;
  logic                  tail_done;

  // Unpack the flat flit bus into one entry per channel.
  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_unpack
    assign flits[i] = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
  end

  // Round-robin search: the lowest requester above last_grant wins;
  // if there is none, wrap around to the lowest requester overall.
  always_comb begin
    pick_wrap   = '0;
    pick_ahead  = '0;
    found_ahead = 1'b0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        pick_wrap = GW'(i);
        if (GW'(i) > last_grant) begin
          pick_ahead  = GW'(i);
          found_ahead = 1'b1;
        end
      end
    end
  end

  // Last flit of the granted packet is being accepted this cycle.
  assign tail_done = (state == ACTIVE) && in_valid[grant] && in_last[grant] && out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(CHANNELS - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (|in_valid) begin
          grant_nxt = found_ahead ? pick_ahead : pick_wrap;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (tail_done) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: pass-through from the granted channel while ACTIVE.
  always_comb begin
    out_flit  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    in_ready  = '0;
    if (state == ACTIVE) begin
      out_flit        = flits[grant];
      out_valid       = in_valid[grant];
      out_last        = in_last[grant];
      in_ready[grant] = out_ready;
    end
  end

endmodule
